// File: rtl/cnn_conv_lane_reduce_if.sv
// Lane-reduce stream bundle: flush control, per-lane pushes, reduced output and status.
// Latency: none (signal bundle only).
// Backpressure: none; producers push freely, overflow is reported through overflow_err.
//
// Ports (master = lane bank / bench side, slave = reduction stage):
//   clear        master->slave  synchronous flush
//   valid_in     master->slave  per-lane push qualifier, bit i = lane i
//   pxl_in       master->slave  lane i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   pxl_out      slave->master  reduced sum
//   valid_out    slave->master  pxl_out qualifier
//   frame_done   slave->master  pulse with the last pixel of a frame
//   overflow_err slave->master  sticky skew-FIFO overflow flag
interface cnn_conv_lane_reduce_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 8
);
    logic                            clear;
    logic [NUM_LANES-1:0]            valid_in;
    logic [NUM_LANES*DATA_WIDTH-1:0] pxl_in;
    logic [DATA_WIDTH-1:0]           pxl_out;
    logic                            valid_out;
    logic                            frame_done;
    logic                            overflow_err;

    modport master (
        output clear, valid_in, pxl_in,
        input  pxl_out, valid_out, frame_done, overflow_err
    );

    modport slave (
        input  clear, valid_in, pxl_in,
        output pxl_out, valid_out, frame_done, overflow_err
    );
endinterface

// File: rtl/cnn_conv_lane_reduce.sv
// Sums NUM_LANES skewed fp32 partial-sum lanes into one stream via skew FIFOs and an fp_add_sub tree.
// Latency: pop to valid_out = 2 + log2(NUM_LANES)*ADD_LAT cycles (+1 with CNN_LANE_REDUCE_RELU_EN).
// Backpressure: none; 1 result/cycle, a push into a full FIFO with no pop is dropped and sets overflow_err.
//
// Ports: clk, reset (async, active-high), bus (cnn_conv_lane_reduce_if.slave).
// Optional macro CNN_LANE_REDUCE_RELU_EN adds a registered ReLU after the tree (negative and -0.0 -> +0).
// fp_add_sub: fp32 add/sub, round-to-nearest-even, denormals flushed to zero, no inf/NaN inputs expected.

module fp_add_sub #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        valid_out
);
    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] big, sml;
        logic [26:0] mb, ms, msh;      // 1.23 mantissa plus guard/round/sticky
        logic [27:0] s;
        logic [9:0]  e;                // bit 9 set means the exponent went negative
        logic [7:0]  d;
        logic [4:0]  lz;
        logic [24:0] r;
        logic        inc;
        if (x[30:0] >= y[30:0]) begin big = x; sml = y; end
        else begin big = y; sml = x; end
        if (big[30:23] == 8'd0) return 32'd0;
        if (sml[30:23] == 8'd0) return big;
        mb = {1'b1, big[22:0], 3'b000};
        ms = {1'b1, sml[22:0], 3'b000};
        d  = big[30:23] - sml[30:23];
        if (d > 8'd26) msh = 27'd1;
        else begin
            msh    = ms >> d;
            msh[0] = msh[0] | (|(ms & ((27'd1 << d) - 27'd1)));
        end
        if (big[31] == sml[31]) s = {1'b0, mb} + {1'b0, msh};
        else                    s = {1'b0, mb} - {1'b0, msh};
        if (s == 28'd0) return 32'd0;
        e = {2'b00, big[30:23]};
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            // highest set bit wins because the loop runs upward
            lz = 5'd0;
            for (int i = 0; i <= 26; i++) if (s[i]) lz = 5'(26 - i);
            s = s << lz;
            e = e - {5'd0, lz};
        end
        inc = s[2] & (s[1] | s[0] | s[3]);
        r   = {1'b0, s[26:3]} + {24'd0, inc};
        if (r[24]) begin r = r >> 1; e = e + 10'd1; end
        if (e[9] || e == 10'd0) return {big[31], 31'd0};
        if (e >= 10'd255)       return {big[31], 8'hFF, 23'd0};
        return {big[31], e[7:0], r[22:0]};
    endfunction

    logic [31:0]    pipe_dat [LAT];
    logic [LAT-1:0] pipe_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) pipe_dat[i] <= 32'd0;
            pipe_vld <= '0;
        end else begin
            pipe_dat[0] <= fadd(a, {b[31] ^ sub, b[30:0]});
            pipe_vld[0] <= valid_in;
            for (int i = 1; i < LAT; i++) begin
                pipe_dat[i] <= pipe_dat[i-1];
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    assign result    = pipe_dat[LAT-1];
    assign valid_out = pipe_vld[LAT-1];
endmodule

module cnn_conv_lane_reduce #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADD_LAT    = 1,
    parameter int OUT_PIXELS = 374544
) (
    input  logic                   clk,
    input  logic                   reset,
    cnn_conv_lane_reduce_if.slave  bus
);
    localparam int LEVELS = $clog2(NUM_LANES);
    localparam int PW     = $clog2(FIFO_DEPTH);
`ifdef CNN_LANE_REDUCE_RELU_EN
    localparam int LAT    = 3 + LEVELS * ADD_LAT;
`else
    localparam int LAT    = 2 + LEVELS * ADD_LAT;
`endif
    localparam int DRW    = $clog2(LAT + 1);
    localparam int CW     = $clog2(OUT_PIXELS + 1);

    logic [NUM_LANES-1:0]  not_empty, full, push;
    logic [DATA_WIDTH-1:0] head [NUM_LANES];
    logic                  pop;

    // A word written this cycle only becomes visible through not_empty next cycle,
    // so an empty FIFO can never push and pop together.
    assign pop = (&not_empty) && !bus.clear;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PW:0]           wr_ptr, rd_ptr;

        assign not_empty[i] = (wr_ptr != rd_ptr);
        assign full[i]      = ((wr_ptr - rd_ptr) == (PW+1)'(FIFO_DEPTH));
        assign push[i]      = bus.valid_in[i] && !bus.clear && (!full[i] || pop);
        assign head[i]      = mem[rd_ptr[PW-1:0]];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else if (bus.clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[i]) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (push[i]) mem[wr_ptr[PW-1:0]] <= bus.pxl_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                           bus.overflow_err <= 1'b0;
        else if (bus.clear)                                  bus.overflow_err <= 1'b0;
        else if (|(bus.valid_in & full) && !pop)             bus.overflow_err <= 1'b1;
    end

    // Stage 0: every lane head is captured together on a pop.
    logic [DATA_WIDTH-1:0] op_dat [NUM_LANES];
    logic                  op_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) op_dat[i] <= '0;
            op_vld <= 1'b0;
        end else begin
            op_vld <= pop;
            if (pop) for (int i = 0; i < NUM_LANES; i++) op_dat[i] <= head[i];
        end
    end

    // Level k holds NUM_LANES>>k live nodes; node j pairs j with j+half of the level below.
    logic [DATA_WIDTH-1:0] node_dat [LEVELS+1][NUM_LANES];
    logic                  node_vld [LEVELS+1][NUM_LANES];

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_l0
        assign node_dat[0][j] = op_dat[j];
        assign node_vld[0][j] = op_vld;
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int W = NUM_LANES >> k;
        for (genvar j = 0; j < NUM_LANES; j++) begin : g_node
            if (j < W) begin : g_add
                fp_add_sub #(.LAT(ADD_LAT)) u_add (
                    .clk       (clk),
                    .reset     (reset),
                    .valid_in  (node_vld[k-1][j] && node_vld[k-1][j+W]),
                    .sub       (1'b0),
                    .a         (node_dat[k-1][j]),
                    .b         (node_dat[k-1][j+W]),
                    .result    (node_dat[k][j]),
                    .valid_out (node_vld[k][j])
                );
            end else begin : g_idle
                assign node_dat[k][j] = '0;
                assign node_vld[k][j] = 1'b0;
            end
        end
    end

    logic [DATA_WIDTH-1:0] fin_dat;
    logic                  fin_vld;

`ifdef CNN_LANE_REDUCE_RELU_EN
    logic [DATA_WIDTH-1:0] relu_dat;
    logic                  relu_vld;

    // Sign bit alone decides, so -0.0 also collapses to +0.0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            relu_dat <= '0;
            relu_vld <= 1'b0;
        end else begin
            relu_vld <= node_vld[LEVELS][0];
            relu_dat <= node_dat[LEVELS][0][DATA_WIDTH-1] ? '0 : node_dat[LEVELS][0];
        end
    end

    assign fin_dat = relu_dat;
    assign fin_vld = relu_vld;
`else
    assign fin_dat = node_dat[LEVELS][0];
    assign fin_vld = node_vld[LEVELS][0];
`endif

    logic           out_vld_q;
    logic [DRW-1:0] drain;
    logic [CW-1:0]  pix_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld_q   <= 1'b0;
            bus.pxl_out <= '0;
        end else begin
            out_vld_q <= fin_vld;
            if (fin_vld) bus.pxl_out <= fin_dat;
        end
    end

    // After a clear, everything still in the pipe surfaces within LAT cycles;
    // the drain window hides exactly those results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               drain <= '0;
        else if (bus.clear)      drain <= DRW'(LAT);
        else if (drain != '0)    drain <= drain - 1'b1;
    end

    assign bus.valid_out  = out_vld_q && (drain == '0);
    assign bus.frame_done = bus.valid_out && (pix_cnt == CW'(OUT_PIXELS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               pix_cnt <= '0;
        else if (bus.clear)      pix_cnt <= '0;
        else if (bus.frame_done) pix_cnt <= '0;
        else if (bus.valid_out)  pix_cnt <= pix_cnt + 1'b1;
    end
endmodule
